// File: rtl/subtracter32bit_arbiter.sv
// subtracter32bit_arbiter: one shared 32-bit subtracter time-multiplexed
// between NREQ valid/ready requesters, with a registered, tagged response.
// Build option: define SUBARB_RR_EN for round-robin arbitration; without it
// the lowest-indexed valid requester always wins and no pointer exists.

// Shared datapath: 33-bit result, bit 32 is the unsigned borrow.
module subtracter32bit (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [32:0] result
);
  assign result = {1'b0, a} - {1'b0, b};
endmodule

module subtracter32bit_arbiter #(
  parameter  int NREQ = 4,
  localparam int ID_W = ($clog2(NREQ) > 1) ? $clog2(NREQ) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ*32-1:0]   req_a,
  input  logic [NREQ*32-1:0]   req_b,
  output logic [NREQ-1:0]      req_ready,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic [ID_W-1:0]      resp_id,
  output logic [32:0]          resp_result,
  output logic                 busy
);

  typedef enum logic [1:0] {IDLE, CALC, RESP} state_t;

  state_t                 state, state_nxt;
  logic [NREQ-1:0][31:0]  a_lane, b_lane;
  logic [31:0]            op_a, op_b;
  logic [ID_W-1:0]        op_id;
  logic [32:0]            sub_res;
  logic                   gnt_vld;
  logic [ID_W-1:0]        gnt;
  logic                   lo_vld;
  logic [ID_W-1:0]        lo_idx;

  assign a_lane = req_a;
  assign b_lane = req_b;
  assign busy   = (state != IDLE);

  // Lowest-index valid requester (fixed priority, and the wrap-around half of RR).
  always_comb begin
    lo_vld = 1'b0;
    lo_idx = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (!lo_vld && req_valid[i]) begin
        lo_vld = 1'b1;
        lo_idx = ID_W'(i);
      end
    end
  end

`ifdef SUBARB_RR_EN
  logic [ID_W-1:0] ptr;
  logic            hi_vld;
  logic [ID_W-1:0] hi_idx;

  // Round-robin: first valid at or above the pointer, else wrap to the lowest.
  always_comb begin
    hi_vld = 1'b0;
    hi_idx = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (!hi_vld && req_valid[i] && (ID_W'(i) >= ptr)) begin
        hi_vld = 1'b1;
        hi_idx = ID_W'(i);
      end
    end
    gnt_vld = hi_vld | lo_vld;
    gnt     = hi_vld ? hi_idx : lo_idx;
  end

  // Pointer moves to the slot after the winner, only when a grant happens.
  always_ff @(posedge clk) begin
    if (rst)
      ptr <= '0;
    else if (state == IDLE && gnt_vld)
      ptr <= (gnt == ID_W'(NREQ-1)) ? '0 : gnt + 1'b1;
  end
`else
  // Fixed priority: lowest index wins.
  always_comb begin
    gnt_vld = lo_vld;
    gnt     = lo_idx;
  end
`endif

  // Accept is only offered in IDLE and never while reset is asserted.
  always_comb begin
    req_ready = '0;
    for (int i = 0; i < NREQ; i++)
      req_ready[i] = (state == IDLE) && !rst && gnt_vld && (gnt == ID_W'(i));
  end

  // Next-state logic: IDLE -> CALC on grant, CALC -> RESP, RESP -> IDLE on accept.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (gnt_vld)    state_nxt = CALC;
      CALC:                    state_nxt = RESP;
      RESP:    if (resp_ready) state_nxt = IDLE;
      default:                 state_nxt = IDLE;
    endcase
  end

  // State and response registers; reset aborts any in-flight operation.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      resp_valid  <= 1'b0;
      resp_id     <= '0;
      resp_result <= '0;
    end else begin
      state <= state_nxt;
      if (state == CALC) begin
        resp_valid  <= 1'b1;
        resp_id     <= op_id;
        resp_result <= sub_res;
      end else if (state == RESP && resp_ready) begin
        resp_valid  <= 1'b0;
      end
    end
  end

  // Operand capture on the handshake edge; feeds the shared subtracter in CALC.
  always_ff @(posedge clk) begin
    if (!rst && state == IDLE && gnt_vld) begin
      op_a  <= a_lane[gnt];
      op_b  <= b_lane[gnt];
      op_id <= gnt;
    end
  end

  subtracter32bit u_sub (
    .a      (op_a),
    .b      (op_b),
    .result (sub_res)
  );

endmodule

// File: tb/tb_subtracter32bit_arbiter.sv
// Self-checking bench for subtracter32bit_arbiter: vector table, directed
// corner sequences, and randomized traffic against a transaction-level model.
module tb_subtracter32bit_arbiter;
  localparam int NREQ = 4;
  localparam int ID_W = 2;

  logic                clk = 1'b0;
  logic                rst;
  logic [NREQ-1:0]     req_valid;
  logic [NREQ*32-1:0]  req_a, req_b;
  logic [NREQ-1:0]     req_ready;
  logic                resp_valid;
  logic                resp_ready;
  logic [ID_W-1:0]     resp_id;
  logic [32:0]         resp_result;
  logic                busy;

  subtracter32bit_arbiter #(.NREQ(NREQ)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_ready(req_ready), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_id(resp_id), .resp_result(resp_result), .busy(busy)
  );

  always #5 clk = ~clk;

  int nvec = 0;
  int nerr = 0;
  int ptr_m = 0;

  typedef struct {
    int          id;
    logic [31:0] a;
    logic [31:0] b;
    logic [32:0] exp;
  } vec_t;
  vec_t tbl [8];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_lane(input int i, input logic [31:0] a, input logic [31:0] b);
    req_a[32*i +: 32] = a;
    req_b[32*i +: 32] = b;
  endtask

  function automatic logic [32:0] ref_sub(input logic [31:0] a, input logic [31:0] b);
    logic [32:0] r;
    r[31:0] = a - b;
    r[32]   = (a < b);
    return r;
  endfunction

  function automatic int winner(input logic [NREQ-1:0] v, input int p);
    int idx;
`ifndef SUBARB_RR_EN
    p = 0;
`endif
    for (int k = 0; k < NREQ; k++) begin
      idx = (p + k) % NREQ;
      if (v[idx]) return idx;
    end
    return -1;
  endfunction

  function automatic logic [NREQ-1:0] onehot(input int g);
    logic [NREQ-1:0] one;
    one = 1;
    return (g < 0) ? '0 : (one << g);
  endfunction

  task automatic note_grant(input int g);
    ptr_m = (g + 1) % NREQ;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_valid = '0;
    step();
    rst = 1'b0;
    ptr_m = 0;
  endtask

  task automatic wait_idle();
    bit done;
    done = 0;
    for (int n = 0; n < 10 && !done; n++) begin
      @(negedge clk);
      if (!busy && !resp_valid) done = 1;
      step();
    end
    if (!done) chk("idle_timeout", 1, 0);
  endtask

  // Wait (bounded) for any grant; returns at negedge with req_ready sampled.
  task automatic wait_grant(output bit ok);
    ok = 0;
    for (int n = 0; n < 10 && !ok; n++) begin
      @(negedge clk);
      if (req_ready != '0) ok = 1;
      else step();
    end
    if (!ok) chk("grant_timeout", 1, 0);
  endtask

  // Single-requester operation with full latency checks.
  task automatic do_op(input int id, input logic [31:0] a, input logic [31:0] b,
                       input logic [32:0] exp);
    req_valid = onehot(id);
    set_lane(id, a, b);
    resp_ready = 1'b1;
    @(negedge clk);
    chk("op_grant", 64'(req_ready), 64'(onehot(id)));
    chk("op_idle_busy", 64'(busy), 0);
    step();
    note_grant(id);
    req_valid = '0;
    @(negedge clk);
    chk("op_calc_valid", 64'(resp_valid), 0);
    chk("op_calc_busy", 64'(busy), 1);
    chk("op_calc_ready", 64'(req_ready), 0);
    step();
    @(negedge clk);
    chk("op_resp_valid", 64'(resp_valid), 1);
    chk("op_resp_id", 64'(resp_id), 64'(id));
    chk("op_resp_result", 64'(resp_result), 64'(exp));
    step();
    @(negedge clk);
    chk("op_done_valid", 64'(resp_valid), 0);
    chk("op_done_busy", 64'(busy), 0);
    step();
  endtask

  initial begin
    bit ok;
    int g, exp_g, exp_id, due, cyc;
    bit outstanding, acc;
    logic [32:0] exp_res;
    logic [32:0] held;
    int rr_seq [5];
    int wrap_seq [2];

    tbl[0] = '{0, 32'h1101_1011, 32'h1011_1101, 33'h0_00EF_FF10};
    tbl[1] = '{2, 32'd5,         32'd7,         33'h1_FFFF_FFFE};
    tbl[2] = '{1, 32'd0,         32'd0,         33'h0_0000_0000};
    tbl[3] = '{3, 32'hFFFF_FFFF, 32'd0,         33'h0_FFFF_FFFF};
    tbl[4] = '{0, 32'd0,         32'd1,         33'h1_FFFF_FFFF};
    tbl[5] = '{1, 32'h8000_0000, 32'h7FFF_FFFF, 33'h0_0000_0001};
    tbl[6] = '{3, 32'd7,         32'd5,         33'h0_0000_0002};
    tbl[7] = '{2, 32'h1234_5678, 32'h1234_5679, 33'h1_FFFF_FFFF};
`ifdef SUBARB_RR_EN
    rr_seq   = '{0, 1, 2, 3, 0};
    wrap_seq = '{3, 1};
`else
    rr_seq   = '{0, 0, 0, 0, 0};
    wrap_seq = '{1, 3};
`endif

    // Reset with all requesters valid: no grant, outputs at reset values.
    rst = 1'b1;
    req_valid = '1;
    resp_ready = 1'b1;
    req_a = {4{32'hDEAD_BEEF}};
    req_b = {4{32'h0000_0001}};
    step();
    step();
    @(negedge clk);
    chk("rst_req_ready", 64'(req_ready), 0);
    chk("rst_resp_valid", 64'(resp_valid), 0);
    chk("rst_resp_id", 64'(resp_id), 0);
    chk("rst_resp_result", 64'(resp_result), 0);
    chk("rst_busy", 64'(busy), 0);
    step();
    rst = 1'b0;
    req_valid = '0;
    ptr_m = 0;
    step();

    // Arithmetic vector table.
    for (int i = 0; i < 8; i++) do_op(tbl[i].id, tbl[i].a, tbl[i].b, tbl[i].exp);

    // Fairness: all four valid, resp_ready high.
    do_reset();
    req_valid = '1;
    resp_ready = 1'b1;
    for (int n = 0; n < 5; n++) begin
      wait_grant(ok);
      if (ok) begin
        chk("fair_grant", 64'(req_ready), 64'(onehot(rr_seq[n])));
        step();
      end
    end
    req_valid = '0;
    wait_idle();

    // Backpressure: resp_ready low for 5 cycles in RESP.
    do_reset();
    req_valid = onehot(1);
    set_lane(1, 32'd9, 32'd4);
    resp_ready = 1'b0;
    @(negedge clk);
    chk("bp_grant", 64'(req_ready), 64'(onehot(1)));
    step();
    req_valid = '1;
    step();
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      chk("bp_valid", 64'(resp_valid), 1);
      chk("bp_id", 64'(resp_id), 1);
      chk("bp_result", 64'(resp_result), 64'(33'h0_0000_0005));
      chk("bp_req_ready", 64'(req_ready), 0);
      chk("bp_busy", 64'(busy), 1);
      step();
    end
    resp_ready = 1'b1;
    step();
    @(negedge clk);
    chk("bp_after_busy", 64'(busy), 0);
    chk("bp_after_valid", 64'(resp_valid), 0);
`ifdef SUBARB_RR_EN
    chk("bp_next_grant", 64'(req_ready), 64'(onehot(2)));
`else
    chk("bp_next_grant", 64'(req_ready), 64'(onehot(0)));
`endif
    req_valid = '0;
    step();

    // Reset during CALC aborts the operation.
    do_reset();
    req_valid = onehot(3);
    set_lane(3, 32'd100, 32'd1);
    resp_ready = 1'b1;
    @(negedge clk);
    chk("abort_grant", 64'(req_ready), 64'(onehot(3)));
    step();
    req_valid = '0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    ptr_m = 0;
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      chk("abort_valid", 64'(resp_valid), 0);
      chk("abort_busy", 64'(busy), 0);
      step();
    end
    req_valid = '1;
    @(negedge clk);
    chk("abort_ptr_grant", 64'(req_ready), 64'(onehot(0)));
    step();
    req_valid = '0;
    wait_idle();

    // Wrap: pointer at 3 after a grant to 2, then requests on 1 and 3.
    do_reset();
    do_op(2, 32'd10, 32'd3, 33'h0_0000_0007);
    req_valid = 4'b1010;
    set_lane(1, 32'd1, 32'd2);
    set_lane(3, 32'd3, 32'd1);
    for (int n = 0; n < 2; n++) begin
      wait_grant(ok);
      if (ok) begin
        chk("wrap_grant", 64'(req_ready), 64'(onehot(wrap_seq[n])));
        step();
        req_valid[wrap_seq[n]] = 1'b0;
      end
    end
    req_valid = '0;
    wait_idle();

    // Randomized traffic against a transaction-level model.
    do_reset();
    outstanding = 0;
    exp_id = 0;
    exp_res = '0;
    due = 0;
    cyc = 0;
    for (int t = 0; t < 800; t++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!req_valid[i] && ($urandom % 3) == 0) begin
          req_valid[i] = 1'b1;
          if ($urandom % 2) set_lane(i, $urandom, $urandom);
          else set_lane(i, $urandom % 8, $urandom % 8);
        end else if (req_valid[i] && ($urandom % 16) == 0) begin
          req_valid[i] = 1'b0;
        end
      end
      resp_ready = ($urandom % 3) != 0;
      @(negedge clk);
      cyc++;
      exp_g = -1;
      if (outstanding) begin
        chk("rnd_busy_ready", 64'(req_ready), 0);
        chk("rnd_busy", 64'(busy), 1);
        chk("rnd_valid", 64'(resp_valid), 64'(cyc >= due));
        if (resp_valid) begin
          chk("rnd_id", 64'(resp_id), 64'(exp_id));
          chk("rnd_result", 64'(resp_result), 64'(exp_res));
        end
      end else begin
        exp_g = winner(req_valid, ptr_m);
        chk("rnd_idle_valid", 64'(resp_valid), 0);
        chk("rnd_idle_busy", 64'(busy), 0);
        chk("rnd_grant", 64'(req_ready), 64'(onehot(exp_g)));
      end
      acc = outstanding && (cyc >= due) && resp_ready;
      g = exp_g;
      step();
      if (acc) outstanding = 0;
      if (g >= 0) begin
        outstanding = 1;
        exp_id = g;
        held = ref_sub(req_a[32*g +: 32], req_b[32*g +: 32]);
        exp_res = held;
        due = cyc + 2;
        ptr_m = (g + 1) % NREQ;
        if (($urandom % 4) == 0) set_lane(g, $urandom, $urandom);
        else req_valid[g] = 1'b0;
      end
    end
    req_valid = '0;
    resp_ready = 1'b1;
    wait_idle();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  // Global time bound so the bench always terminates.
  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
